multicycle_control_fsm: RTL

Sequential control unit for the multicycle RV32I datapath. It drives the shared ALU's 4-bit operation code and all datapath selects and strobes. It steps each instruction through fetch, decode, execute, memory and writeback states, and it waits on a ready handshake with unified memory. It sits between the instruction register and the datapath and is the initiator side of the ALU operation interface.

---
 rtl/rv32i_pkg.sv | 71 +++++++
 rtl/alu_op_decoder.sv | 67 ++++++
 rtl/multicycle_control_fsm.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: ALU operation codes, opcodes, datapath select
// encodings and the multicycle control state type.
package rv32i_pkg;

  localparam logic [3:0] ALU_ADD    = 4'b0000;
  localparam logic [3:0] ALU_SUB    = 4'b0001;
  localparam logic [3:0] ALU_AND    = 4'b0010;
  localparam logic [3:0] ALU_OR     = 4'b0011;
  localparam logic [3:0] ALU_XOR    = 4'b0100;
  localparam logic [3:0] ALU_SLL    = 4'b0101;
  localparam logic [3:0] ALU_SRL    = 4'b0110;
  localparam logic [3:0] ALU_SRA    = 4'b0111;
  localparam logic [3:0] ALU_SLT    = 4'b1000;
  localparam logic [3:0] ALU_SLTU   = 4'b1001;
  localparam logic [3:0] ALU_PASS_B = 4'b1010;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [1:0] {
    SRC_A_RS1    = 2'd0,
    SRC_A_PC     = 2'd1,
    SRC_A_OLD_PC = 2'd2
  } src_a_e;

  typedef enum logic [1:0] {
    SRC_B_RS2  = 2'd0,
    SRC_B_IMM  = 2'd1,
    SRC_B_FOUR = 2'd2
  } src_b_e;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4
  } imm_sel_e;

  typedef enum logic [1:0] {
    PC_SRC_ALU    = 2'd0,
    PC_SRC_ALUOUT = 2'd1,
    PC_SRC_JALR   = 2'd2
  } pc_src_e;

  typedef enum logic [1:0] {
    WB_ALUOUT = 2'd0,
    WB_MEM    = 2'd1,
    WB_PC     = 2'd2
  } wb_sel_e;

  typedef enum logic [2:0] {
    ST_INIT    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_EXECUTE = 3'd3,
    ST_MEM     = 3'd4,
    ST_WB      = 3'd5,
    ST_TRAP    = 3'd6
  } state_e;

endpackage

// File: rtl/alu_op_decoder.sv
// Combinational decode of opcode/funct3/funct7 into the EXECUTE-stage ALU
// operation, plus detection of encodings this core does not implement.
module alu_op_decoder
  import rv32i_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic [3:0] alu_op,
  output logic       illegal
);

  logic [3:0] funct_op;

  always_comb begin
    funct_op = ALU_AND;
    case (funct3)
      3'b000:  funct_op = ALU_ADD;
      3'b001:  funct_op = ALU_SLL;
      3'b010:  funct_op = ALU_SLT;
      3'b011:  funct_op = ALU_SLTU;
      3'b100:  funct_op = ALU_XOR;
      3'b101:  funct_op = funct7[5] ? ALU_SRA : ALU_SRL;
      3'b110:  funct_op = ALU_OR;
      default: funct_op = ALU_AND;
    endcase
  end

  always_comb begin
    alu_op  = ALU_ADD;
    illegal = 1'b0;
    case (opcode)
      OPC_OP: begin
        alu_op = (funct3 == 3'b000 && funct7 == 7'b0100000) ? ALU_SUB : funct_op;
        if (funct7 == 7'b0100000)
          illegal = !(funct3 == 3'b000 || funct3 == 3'b101);
        else if (funct7 != 7'd0)
          illegal = 1'b1;
      end
      OPC_OP_IMM: begin
        alu_op = funct_op;
        // Only the shift forms carry a funct7 field in the immediate.
        if (funct3 == 3'b001)
          illegal = (funct7 != 7'd0);
        else if (funct3 == 3'b101)
          illegal = !(funct7 == 7'd0 || funct7 == 7'b0100000);
      end
      OPC_LUI:    alu_op = ALU_PASS_B;
      OPC_AUIPC:  alu_op = ALU_ADD;
      OPC_JAL:    alu_op = ALU_ADD;
      OPC_FENCE:  alu_op = ALU_ADD;
      OPC_LOAD:   illegal = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
      OPC_STORE:  illegal = (funct3 > 3'b010);
      OPC_JALR:   illegal = (funct3 != 3'b000);
      OPC_BRANCH: begin
        illegal = (funct3[2:1] == 2'b01);
        case (funct3[2:1])
          2'b00:   alu_op = ALU_SUB;
          2'b10:   alu_op = ALU_SLT;
          default: alu_op = ALU_SLTU;
        endcase
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle RV32I control unit: steps each instruction through
// FETCH/DECODE/EXECUTE/MEM/WB and drives all datapath selects and strobes.
module multicycle_control_fsm
  import rv32i_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        mem_ready,
  input  logic        alu_zero,
  input  logic        alu_lsb,
  output logic [3:0]  alu_op,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [2:0]  imm_sel,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic        ir_write,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic        reg_write,
  output logic [1:0]  wb_sel,
  output logic        illegal,
  output logic [31:0] instret
);

  state_e     state;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [3:0] dec_alu_op;
  logic       dec_illegal;
  logic       is_load, is_store, is_ctrl, br_taken;
  logic       unused_instr;

  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign is_load  = (opcode == OPC_LOAD);
  assign is_store = (opcode == OPC_STORE);
  assign is_ctrl  = (opcode == OPC_BRANCH) || (opcode == OPC_JAL) || (opcode == OPC_JALR);
  // Register and immediate fields are consumed by the datapath, not here.
  assign unused_instr = ^{instr[24:15], instr[11:7]};

  // funct3[2] picks the SLT/SLTU result over the zero flag; funct3[0] inverts.
  assign br_taken = (funct3[2] ? alu_lsb : alu_zero) ^ funct3[0];

  alu_op_decoder u_alu_op_decoder (
    .opcode  (opcode),
    .funct3  (funct3),
    .funct7  (instr[31:25]),
    .alu_op  (dec_alu_op),
    .illegal (dec_illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_INIT;
      instret <= 32'd0;
    end else begin
      case (state)
        ST_INIT:  state <= ST_FETCH;
        ST_FETCH: if (mem_ready) state <= ST_DECODE;
        ST_DECODE: begin
          if (dec_illegal) begin
            state <= ST_TRAP;
          end else if (opcode == OPC_FENCE) begin
            state   <= ST_FETCH;
            instret <= instret + 32'd1;
          end else begin
            state <= ST_EXECUTE;
          end
        end
        ST_EXECUTE: begin
          if (is_load || is_store) begin
            state <= ST_MEM;
          end else if (is_ctrl) begin
            state   <= ST_FETCH;
            instret <= instret + 32'd1;
          end else begin
            state <= ST_WB;
          end
        end
        ST_MEM: begin
          if (mem_ready) begin
            if (is_store) begin
              state   <= ST_FETCH;
              instret <= instret + 32'd1;
            end else begin
              state <= ST_WB;
            end
          end
        end
        ST_WB: begin
          state   <= ST_FETCH;
          instret <= instret + 32'd1;
        end
        ST_TRAP: state <= ST_TRAP;
        default: state <= ST_INIT;
      endcase
    end
  end

  always_comb begin
    alu_op       = ALU_ADD;
    alu_src_a    = SRC_A_RS1;
    alu_src_b    = SRC_B_RS2;
    imm_sel      = IMM_I;
    pc_write     = 1'b0;
    pc_src       = PC_SRC_ALU;
    ir_write     = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    reg_write    = 1'b0;
    wb_sel       = WB_ALUOUT;
    illegal      = 1'b0;
    case (state)
      ST_FETCH: begin
        mem_req   = 1'b1;
        alu_src_a = SRC_A_PC;
        alu_src_b = SRC_B_FOUR;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
        end
      end
      ST_DECODE: begin
        // Branch/jump target is formed here and parked in ALUOut.
        alu_src_a = SRC_A_OLD_PC;
        alu_src_b = SRC_B_IMM;
        imm_sel   = (opcode == OPC_JAL) ? IMM_J : IMM_B;
      end
      ST_EXECUTE: begin
        alu_op = dec_alu_op;
        case (opcode)
          OPC_OP_IMM: alu_src_b = SRC_B_IMM;
          OPC_LUI: begin
            alu_src_b = SRC_B_IMM;
            imm_sel   = IMM_U;
          end
          OPC_AUIPC: begin
            alu_src_a = SRC_A_OLD_PC;
            alu_src_b = SRC_B_IMM;
            imm_sel   = IMM_U;
          end
          OPC_LOAD: alu_src_b = SRC_B_IMM;
          OPC_STORE: begin
            alu_src_b = SRC_B_IMM;
            imm_sel   = IMM_S;
          end
          OPC_BRANCH: begin
            pc_write = br_taken;
            pc_src   = PC_SRC_ALUOUT;
          end
          OPC_JAL: begin
            pc_write  = 1'b1;
            pc_src    = PC_SRC_ALUOUT;
            reg_write = 1'b1;
            wb_sel    = WB_PC;
          end
          OPC_JALR: begin
            alu_src_b = SRC_B_IMM;
            pc_write  = 1'b1;
            pc_src    = PC_SRC_JALR;
            reg_write = 1'b1;
            wb_sel    = WB_PC;
          end
          default: ;
        endcase
      end
      ST_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = is_store;
      end
      ST_WB: begin
        reg_write = 1'b1;
        wb_sel    = is_load ? WB_MEM : WB_ALUOUT;
      end
      ST_TRAP: illegal = 1'b1;
      default: ;
    endcase
  end

endmodule
